sync_tx_sched: RTL and testbench
================================

// Module: sync_tx_sched
// PURPOSE
//  Round-robin scheduler sharing one sync_multi transmit port among NUM_REQ clk_tx-domain requesters.
//  Picks one pending request and drives the word onto in_data with the v/f four-phase handshake.
//  Holds the word stable until the synchronizer releases f, then serves the next requester.
//  Sits in the clk_tx domain directly in front of sync_multi; the rx side is untouched.
// PARAMETERS
//  NUM_REQ     4    number of requesters (>=2)
//  DATA_WIDTH  8    word width, equals sync_multi DATA_WIDTH
//  TIMEOUT     64   max clk_tx cycles a transfer may stay in flight before err
// PORTS
//  clk_tx      in   1                   single clock (transmit-side clock)
//  reset       in   1                   asynchronous, active-low reset
//  req         in   NUM_REQ             level request per requester, held until gnt
//  req_data    in   NUM_REQ*DATA_WIDTH  word i at [i*DATA_WIDTH +: DATA_WIDTH]
//  gnt         out  NUM_REQ             one-hot 1-cycle pulse: word i captured
//  in_data     out  DATA_WIDTH          to sync_multi in_data
//  v           out  1                   to sync_multi v (launch, level)
//  f           in   1                   from sync_multi f: high while transfer in flight
//  busy        out  1                   high whenever state != IDLE
//  src_id      out  clog2(NUM_REQ)      index of requester owning current or last transfer
//  err         out  1                   sticky: transfer exceeded TIMEOUT
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; gnt=0, in_data=0, v=0, busy=0, src_id=0, err=0, rr ptr=0, timer=0.
//  States: IDLE -> LAUNCH -> WAIT_ACK -> WAIT_REL -> IDLE.
//  IDLE: if |req and f==0: pick first set req at/after ptr (wrap-around); capture word into in_data;
//   gnt[i]=1 for that one cycle; src_id=i; ptr=i+1 mod NUM_REQ; go LAUNCH. f==1 in IDLE: wait, no grant.
//  LAUNCH: v=1; go WAIT_ACK. Latency req high (IDLE) -> gnt same edge -> v one cycle later.
//  WAIT_ACK: v held 1 until f sampled 1, then v=0 at next edge; go WAIT_REL.
//  WAIT_REL: v=0; when f sampled 0 go IDLE. in_data constant from capture until IDLE re-entered.
//  Earliest back-to-back: new gnt in the first IDLE cycle after f falls.
//  Timer: clears on LAUNCH, +1 each cycle in WAIT_ACK/WAIT_REL; at TIMEOUT: err=1 (sticky to reset),
//   v=0, state IDLE, in_data kept. Saturates, never wraps.
//  Simultaneous requests: only rr winner granted; others stay pending, none dropped.
//  Requester deasserting req before gnt: legal, simply not served. req_data sampled only at gnt edge.
//  Starvation bound: pending requester served within NUM_REQ transfers.
//  Reset mid-transfer: v and all outputs drop immediately; sync_multi must be reset alongside.
// STRUCTURE
//  sync_pkg: state encoding (IDLE/LAUNCH/WAIT_ACK/WAIT_REL), clog2 function, default TIMEOUT.
//  Sub-module rr_arbiter (req, ptr -> one-hot grant, index); FSM, timer, data register in top.
// TESTING
//  Reset 0 with req=4'b1111 -> gnt=0, v=0, busy=0; release, f model idle -> gnt=0001, in_data=req_data[0].
//  req=4'b0101 held, f model acks 3 cycles after v -> gnt order 0,2,0,2; in_data stable while v|f.
//  Single req[3], data 8'hA5 -> gnt[3] at T, v rises T+1, falls 1 cycle after f=1; src_id=3.
//  f never rises after v -> err=1 at 64 cycles in flight, v=0, busy=0; err stays 1 until reset.
//  f already high at idle, req[1]=1 -> no gnt until f=0, then gnt[1] next edge.
//  Assert reset while in WAIT_REL -> v=0, busy=0, gnt=0 asynchronously, ptr back to 0.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared types and helpers for the clk_tx-side transmit scheduler.
package sync_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_ACK = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT = 64;

  // Index width, never below 1 so single-bit fields stay legal.
  function automatic int clog2(input int n);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < n) begin
      p = p * 2;
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, with wrap-around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [IDX_W-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/sync_tx_sched.sv
// Round-robin scheduler feeding one sync_multi transmit port through the v/f handshake.
//  state    | meaning
//  IDLE     | waiting for a request with f low; grants and captures the word
//  LAUNCH   | word stable on in_data; raise v next edge, clear timer
//  WAIT_ACK | v high until f seen high
//  WAIT_REL | v low until f seen low
module sync_tx_sched
  import sync_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  localparam int IDX_W     = clog2(NUM_REQ),
  localparam int TMR_W     = clog2(TIMEOUT + 1)
) (
  input  logic                          clk_tx,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [DATA_WIDTH-1:0]         in_data,
  output logic                          v,
  input  logic                          f,
  output logic                          busy,
  output logic [IDX_W-1:0]              src_id,
  output logic                          err
);

  state_t               state;
  logic [IDX_W-1:0]     ptr;
  logic [TMR_W-1:0]     timer;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic [DATA_WIDTH-1:0] sel_word;
  logic [IDX_W-1:0]     ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // One-hot AND-OR mux keeps the word select free of variable part-selects.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_word = sel_word | req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign ptr_next = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk_tx or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gnt     <= '0;
      in_data <= '0;
      v       <= 1'b0;
      src_id  <= '0;
      err     <= 1'b0;
      ptr     <= '0;
      timer   <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (arb_valid && !f) begin
            gnt     <= arb_grant;
            in_data <= sel_word;
            src_id  <= arb_idx;
            ptr     <= ptr_next;
            state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          v     <= 1'b1;
          timer <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK, WAIT_REL: begin
          // Timeout wins over any handshake event in the same cycle; timer parks at TIMEOUT.
          if (timer >= TMR_W'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            v     <= 1'b0;
            timer <= TMR_W'(TIMEOUT);
            state <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
            if (state == WAIT_ACK && f) begin
              v     <= 1'b0;
              state <= WAIT_REL;
            end else if (state == WAIT_REL && !f) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_tx_sched.sv
// Directed bench for sync_tx_sched with a behavioural sync_multi f responder and grant scoreboard.
module tb_sync_tx_sched;

  logic        clk_tx = 1'b0;
  logic        reset  = 1'b0;
  logic [3:0]  req    = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  gnt;
  logic [7:0]  in_data;
  logic        v;
  logic        f;
  logic        busy;
  logic [1:0]  src_id;
  logic        err;

  always #5 clk_tx = ~clk_tx;

  sync_tx_sched #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .TIMEOUT    (64)
  ) dut (
    .clk_tx   (clk_tx),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .in_data  (in_data),
    .v        (v),
    .f        (f),
    .busy     (busy),
    .src_id   (src_id),
    .err      (err)
  );

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] cur_data = '0;

  // f responder: rises after v has been seen high ack_dly times, falls rel_dly cycles after v drops.
  int   ack_dly = 3;
  int   rel_dly = 2;
  logic ack_en = 1'b1;
  logic f_ovr_en = 1'b0;
  logic f_ovr_val = 1'b0;
  logic f_auto;
  int   f_cnt;

  always @(posedge clk_tx or negedge reset) begin
    if (!reset) begin
      f_auto <= 1'b0;
      f_cnt  <= 0;
    end else if (!f_auto) begin
      if (v && ack_en) begin
        if (f_cnt >= ack_dly - 1) begin
          f_auto <= 1'b1;
          f_cnt  <= 0;
        end else f_cnt <= f_cnt + 1;
      end else f_cnt <= 0;
    end else if (!v) begin
      if (f_cnt >= rel_dly - 1) begin
        f_auto <= 1'b0;
        f_cnt  <= 0;
      end else f_cnt <= f_cnt + 1;
    end
  end

  assign f = f_ovr_en ? f_ovr_val : f_auto;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every grant must match the next expected requester and word.
  always @(negedge clk_tx) begin
    exp_t e;
    if (reset) begin
      if (gnt != 4'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_gnt", {28'b0, gnt}, 32'h0);
        end else begin
          e = sb.pop_front();
          check("gnt_onehot", {28'b0, gnt}, 32'(1 << e.idx));
          check("src_id", {30'b0, src_id}, 32'(e.idx));
          check("in_data_capture", {24'b0, in_data}, {24'b0, e.data});
          cur_data = e.data;
        end
      end
      if (busy) check("in_data_stable", {24'b0, in_data}, {24'b0, cur_data});
    end
  end

  task automatic wait_gnt(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_tx);
      if (gnt != 4'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("gnt_within_budget", {31'b0, seen}, 32'h1);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_tx);
      if (!busy && !f) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_within_budget", {31'b0, done}, 32'h1);
  endtask

  initial begin
    int  tg, tvr, tfh, tvf, t, vcnt;
    bit  saw, found;

    // Reset held with all requests pending
    req      = 4'b1111;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (3) @(negedge clk_tx);
    check("rst_gnt", {28'b0, gnt}, 32'h0);
    check("rst_v", {31'b0, v}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_in_data", {24'b0, in_data}, 32'h0);
    check("rst_src_id", {30'b0, src_id}, 32'h0);
    sb.push_back('{idx: 0, data: 8'h11});
    reset = 1'b1;
    wait_gnt(20);
    req = 4'b0;
    wait_idle(50);

    // Two requesters held high alternate 0,2,0,2 from a fresh pointer
    @(negedge clk_tx);
    reset    = 1'b0;
    req      = 4'b0101;
    req_data = {8'h44, 8'hC2, 8'h22, 8'hC0};
    sb.push_back('{idx: 0, data: 8'hC0});
    sb.push_back('{idx: 2, data: 8'hC2});
    sb.push_back('{idx: 0, data: 8'hC0});
    sb.push_back('{idx: 2, data: 8'hC2});
    @(negedge clk_tx);
    reset = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_tx);
      if (sb.size() == 0) break;
    end
    check("rr_all_served", 32'(sb.size()), 32'h0);
    req = 4'b0;
    wait_idle(50);

    // Single requester 3: handshake latencies
    req_data[31:24] = 8'hA5;
    sb.push_back('{idx: 3, data: 8'hA5});
    req = 4'b1000;
    tg = -1; tvr = -1; tfh = -1; tvf = -1; t = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_tx);
      t++;
      if (gnt[3] && tg < 0) begin
        tg  = t;
        req = 4'b0;
      end
      if (v && tvr < 0) tvr = t;
      if (f && tfh < 0) tfh = t;
      if (tvr >= 0 && !v && tvf < 0) tvf = t;
      if (tvf >= 0 && !busy && !f) break;
    end
    check("t3_gnt_seen", {31'b0, tg >= 0}, 32'h1);
    check("t3_v_rise_lat", 32'(tvr), 32'(tg + 1));
    check("t3_v_fall_lat", 32'(tvf), 32'(tfh + 1));
    check("t3_src_id", {30'b0, src_id}, 32'h3);
    wait_idle(50);

    // f never acknowledges: timeout after 64 cycles in flight
    ack_en         = 1'b0;
    req_data[15:8] = 8'h3C;
    sb.push_back('{idx: 1, data: 8'h3C});
    req  = 4'b0010;
    vcnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_tx);
      if (gnt[1]) req = 4'b0;
      if (v) vcnt++;
      if (err) break;
    end
    check("t4_err", {31'b0, err}, 32'h1);
    check("t4_v_cycles", 32'(vcnt), 32'd64);
    check("t4_v_low", {31'b0, v}, 32'h0);
    check("t4_busy", {31'b0, busy}, 32'h0);
    check("t4_in_data_kept", {24'b0, in_data}, 32'h3C);
    repeat (10) @(negedge clk_tx);
    check("t4_err_sticky", {31'b0, err}, 32'h1);
    check("t4_still_idle", {31'b0, busy}, 32'h0);
    ack_en = 1'b1;

    // f already high at idle blocks the grant until it falls
    f_ovr_en       = 1'b1;
    f_ovr_val      = 1'b1;
    req_data[15:8] = 8'h5A;
    sb.push_back('{idx: 1, data: 8'h5A});
    req = 4'b0010;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk_tx);
      if (gnt != 4'b0) saw = 1'b1;
    end
    check("t5_no_gnt_while_f", {31'b0, saw}, 32'h0);
    check("t5_busy_while_f", {31'b0, busy}, 32'h0);
    f_ovr_val = 1'b0;
    @(negedge clk_tx);
    check("t5_gnt_after_f_low", {28'b0, gnt}, 32'h2);
    f_ovr_en = 1'b0;
    req      = 4'b0;
    wait_idle(50);

    // Async reset while in WAIT_REL
    rel_dly          = 10;
    req_data[23:16]  = 8'h77;
    sb.push_back('{idx: 2, data: 8'h77});
    req = 4'b0100;
    wait_gnt(20);
    req   = 4'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_tx);
      if (f && !v && busy) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reached_wait_rel", {31'b0, found}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_v", {31'b0, v}, 32'h0);
    check("t6_rst_busy", {31'b0, busy}, 32'h0);
    check("t6_rst_gnt", {28'b0, gnt}, 32'h0);
    check("t6_rst_err", {31'b0, err}, 32'h0);
    check("t6_rst_in_data", {24'b0, in_data}, 32'h0);
    check("t6_rst_src_id", {30'b0, src_id}, 32'h0);
    rel_dly = 2;
    req     = 4'b1111;
    req_data[7:0] = 8'h11;
    sb.push_back('{idx: 0, data: 8'h11});
    @(negedge clk_tx);
    reset = 1'b1;
    wait_gnt(20);
    req = 4'b0;
    wait_idle(50);

    check("sb_empty_at_end", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "simulation time limit reached");
  end

endmodule
